// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, stall indices, load opcodes
// and the packed layouts of the EX->MEM and MEM->WB buses.
package mem_stage_pkg;

  localparam int EX_TO_MEM_WD = 79;
  localparam int MEM_TO_WB_WD = 70;
  localparam int STALL_W      = 6;

  localparam int STALL_MEM = 3;
  localparam int STALL_WB  = 4;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  localparam logic [2:0] MEM_OP_LW  = 3'b000;
  localparam logic [2:0] MEM_OP_LB  = 3'b001;
  localparam logic [2:0] MEM_OP_LBU = 3'b010;
  localparam logic [2:0] MEM_OP_LH  = 3'b011;
  localparam logic [2:0] MEM_OP_LHU = 3'b100;

  typedef struct packed {
    logic [2:0]  mem_op;
    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_to_mem_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } mem_to_wb_t;

  function automatic logic is_load(input ex_to_mem_t b);
    return b.data_ram_en && (b.data_ram_wen == 4'b0000) && b.sel_rf_res;
  endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// Load-extend block: picks the addressed byte/halfword out of the raw word
// and sign- or zero-extends it; unknown opcodes behave as LW.
module mem_stage_load_extend
  import mem_stage_pkg::*;
(
  input  logic [31:0] i_raw,
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_mem_op,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_raw[7:0];
    case (i_addr)
      2'd0: w_byte = i_raw[7:0];
      2'd1: w_byte = i_raw[15:8];
      2'd2: w_byte = i_raw[23:16];
      2'd3: w_byte = i_raw[31:24];
      default: w_byte = i_raw[7:0];
    endcase
    // Halfword ignores addr[0]: misaligned halves are silently realigned.
    w_half = i_addr[1] ? i_raw[31:16] : i_raw[15:0];
  end

  always_comb begin
    o_data = i_raw;
    case (i_mem_op)
      MEM_OP_LB:  o_data = {{24{w_byte[7]}}, w_byte};
      MEM_OP_LBU: o_data = {24'd0, w_byte};
      MEM_OP_LH:  o_data = {{16{w_half[15]}}, w_half};
      MEM_OP_LHU: o_data = {16'd0, w_half};
      default:    o_data = i_raw;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX->MEM bus, extends SRAM load data and
// keeps a copy of it so the result stays stable while the stage is stalled.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [STALL_W-1:0]      stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic                    mem_wreg,
  output logic [4:0]              mem_waddr,
  output logic [31:0]             mem_wdata
);

  ex_to_mem_t r_bus;
  logic       r_hold_valid;
  logic [31:0] r_hold_data;

  logic [31:0] w_raw;
  logic [31:0] w_load_data;
  mem_to_wb_t  w_wb;
  logic        w_unused_stall;

  assign w_unused_stall = ^{stall[5], stall[2:0]};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_bus        <= '0;
      r_hold_valid <= 1'b0;
      r_hold_data  <= 32'd0;
    end else if (stall[STALL_MEM] == STOP && stall[STALL_WB] == NOSTOP) begin
      r_bus        <= '0;
      r_hold_valid <= 1'b0;
    end else if (stall[STALL_MEM] == NOSTOP) begin
      r_bus        <= ex_to_mem_bus;
      r_hold_valid <= 1'b0;
    end else if (is_load(r_bus) && !r_hold_valid) begin
      // SRAM data is only valid in the first MEM cycle; keep it for the stall.
      r_hold_data  <= data_sram_rdata;
      r_hold_valid <= 1'b1;
    end
  end

  assign w_raw = r_hold_valid ? r_hold_data : data_sram_rdata;

  mem_stage_load_extend u_load_extend (
    .i_raw    (w_raw),
    .i_addr   (r_bus.ex_result[1:0]),
    .i_mem_op (r_bus.mem_op),
    .o_data   (w_load_data)
  );

  always_comb begin
    w_wb.pc       = r_bus.pc;
    w_wb.rf_we    = r_bus.rf_we;
    w_wb.rf_waddr = r_bus.rf_waddr;
    w_wb.rf_wdata = r_bus.sel_rf_res ? w_load_data : r_bus.ex_result;
  end

  assign mem_to_wb_bus = w_wb;
  assign mem_wreg      = w_wb.rf_we;
  assign mem_waddr     = w_wb.rf_waddr;
  assign mem_wdata     = w_wb.rf_wdata;

endmodule

// File: tb/tb_mem_stage.sv
// Directed scoreboard bench for mem_stage: stimulus pushes the expected WB
// payload for each cycle; a negedge monitor pops and compares.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic                    clk = 1'b0;
  logic                    resetn;
  logic [STALL_W-1:0]      stall;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [31:0]             data_sram_rdata;
  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
  logic                    mem_wreg;
  logic [4:0]              mem_waddr;
  logic [31:0]             mem_wdata;

  mem_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .stall           (stall),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .data_sram_rdata (data_sram_rdata),
    .mem_to_wb_bus   (mem_to_wb_bus),
    .mem_wreg        (mem_wreg),
    .mem_waddr       (mem_waddr),
    .mem_wdata       (mem_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    logic [69:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_vec  = 0;
  int  n_fail = 0;

  localparam logic [5:0] S34 = 6'b011000;
  localparam logic [5:0] S3  = 6'b001000;
  localparam logic [5:0] S0  = 6'b000000;

  function automatic logic [78:0] mk(input logic [2:0] op, input logic [31:0] pc,
                                     input logic en, input logic [3:0] wen,
                                     input logic sel, input logic we,
                                     input logic [4:0] wa, input logic [31:0] res);
    return {op, pc, en, wen, sel, we, wa, res};
  endfunction

  function automatic logic [69:0] wb(input logic [31:0] pc, input logic we,
                                     input logic [4:0] wa, input logic [31:0] wd);
    return {pc, we, wa, wd};
  endfunction

  // Outputs seen now are checked against exp; rn/st/nxt are for the next edge.
  task automatic cyc(input logic rn, input logic [5:0] st, input logic [78:0] nxt,
                     input logic [31:0] rd, input bit chk, input logic [69:0] exp);
    sb_t e;
    @(posedge clk);
    #1;
    data_sram_rdata = rd;
    resetn          = rn;
    stall           = st;
    ex_to_mem_bus   = nxt;
    e.chk = chk;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic cmp(input string name, input logic [69:0] act, input logic [69:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  initial begin : monitor
    sb_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk) begin
          cmp("wb_bus", {0'b0, mem_to_wb_bus}, e.exp);
          cmp("wreg",   70'(mem_wreg),  70'(e.exp[37]));
          cmp("waddr",  70'(mem_waddr), 70'(e.exp[36:32]));
          cmp("wdata",  70'(mem_wdata), 70'(e.exp[31:0]));
        end
      end
    end
  end

  initial begin : stim
    logic [78:0] A, B, C, D, E, F, G, H, I, J, K, L, M;
    int waited;
    A = mk(MEM_OP_LB,  32'h100, 1'b0, 4'h0, 1'b0, 1'b1, 5'd9,  32'h1234_5678);
    B = mk(MEM_OP_LB,  32'h104, 1'b1, 4'h0, 1'b1, 1'b1, 5'd3,  32'h0000_1003);
    C = mk(MEM_OP_LBU, 32'h108, 1'b1, 4'h0, 1'b1, 1'b1, 5'd4,  32'h0000_1003);
    D = mk(MEM_OP_LH,  32'h10C, 1'b1, 4'h0, 1'b1, 1'b1, 5'd5,  32'h0000_2002);
    E = mk(MEM_OP_LHU, 32'h110, 1'b1, 4'h0, 1'b1, 1'b1, 5'd6,  32'h0000_2000);
    F = mk(MEM_OP_LB,  32'h114, 1'b1, 4'h0, 1'b1, 1'b1, 5'd7,  32'h0000_1001);
    G = mk(3'b111,     32'h118, 1'b1, 4'h0, 1'b1, 1'b1, 5'd8,  32'h0000_3004);
    H = mk(MEM_OP_LW,  32'h11C, 1'b1, 4'h0, 1'b1, 1'b1, 5'd10, 32'h0000_3000);
    I = mk(MEM_OP_LW,  32'h120, 1'b1, 4'h0, 1'b1, 1'b1, 5'd11, 32'h0000_3008);
    J = mk(MEM_OP_LW,  32'h124, 1'b0, 4'h0, 1'b0, 1'b1, 5'd12, 32'h0000_0005);
    K = mk(MEM_OP_LW,  32'h128, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0,  32'h0000_4000);
    L = mk(MEM_OP_LW,  32'h12C, 1'b1, 4'h0, 1'b1, 1'b1, 5'd13, 32'h0000_6000);
    M = mk(MEM_OP_LW,  32'h130, 1'b1, 4'h0, 1'b1, 1'b1, 5'd14, 32'h0000_6004);

    resetn = 1'b0; stall = S0; ex_to_mem_bus = A; data_sram_rdata = 32'd0;

    cyc(1'b0, S0,  A,     32'h0,         1, 70'd0);
    cyc(1'b1, S0,  A,     32'h0,         1, 70'd0);
    cyc(1'b1, S0,  B,     32'hFFFF_FFFF, 1, wb(32'h100, 1'b1, 5'd9,  32'h1234_5678));
    cyc(1'b1, S0,  C,     32'h80FF_1234, 1, wb(32'h104, 1'b1, 5'd3,  32'hFFFF_FF80));
    cyc(1'b1, S0,  D,     32'h80FF_1234, 1, wb(32'h108, 1'b1, 5'd4,  32'h0000_0080));
    cyc(1'b1, S0,  E,     32'h8001_7FFF, 1, wb(32'h10C, 1'b1, 5'd5,  32'hFFFF_8001));
    cyc(1'b1, S0,  F,     32'h8001_7FFF, 1, wb(32'h110, 1'b1, 5'd6,  32'h0000_7FFF));
    cyc(1'b1, S0,  G,     32'h80FF_1234, 1, wb(32'h114, 1'b1, 5'd7,  32'h0000_0012));
    cyc(1'b1, S0,  H,     32'h1357_2468, 1, wb(32'h118, 1'b1, 5'd8,  32'h1357_2468));
    cyc(1'b1, S34, I,     32'hDEAD_BEEF, 1, wb(32'h11C, 1'b1, 5'd10, 32'hDEAD_BEEF));
    cyc(1'b1, S34, I,     32'h0,         1, wb(32'h11C, 1'b1, 5'd10, 32'hDEAD_BEEF));
    cyc(1'b1, S34, I,     32'h0,         1, wb(32'h11C, 1'b1, 5'd10, 32'hDEAD_BEEF));
    cyc(1'b1, S0,  I,     32'h0,         1, wb(32'h11C, 1'b1, 5'd10, 32'hDEAD_BEEF));
    cyc(1'b1, S3,  J,     32'hCAFE_F00D, 1, wb(32'h120, 1'b1, 5'd11, 32'hCAFE_F00D));
    cyc(1'b1, S0,  J,     32'hCAFE_F00D, 1, 70'd0);
    cyc(1'b1, S0,  K,     32'h0,         1, wb(32'h124, 1'b1, 5'd12, 32'h0000_0005));
    cyc(1'b1, S0,  L,     32'h0,         1, wb(32'h128, 1'b0, 5'd0,  32'h0000_4000));
    cyc(1'b1, S34, M,     32'h1111_2222, 1, wb(32'h12C, 1'b1, 5'd13, 32'h1111_2222));
    cyc(1'b0, S34, M,     32'h0,         1, wb(32'h12C, 1'b1, 5'd13, 32'h1111_2222));
    cyc(1'b1, S0,  M,     32'h0,         1, 70'd0);
    cyc(1'b1, S0,  79'd0, 32'h0BAD_F00D, 1, wb(32'h130, 1'b1, 5'd14, 32'h0BAD_F00D));
    cyc(1'b1, S0,  79'd0, 32'h0,         0, 70'd0);

    waited = 0;
    while (sb.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    if (sb.size() > 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
